// File: rtl/ws2811_stream_decoder_if.sv
// Bus bundle for the WS2811 receive decoder: serial line in, pixel/frame reports out.
// The decoder takes the slave side; the driver or monitor takes the master side.
interface ws2811_stream_decoder_if;
  logic        serial_in;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  pixel_count;
  logic        frame_error;
  logic        busy;

  modport slave (
    input  serial_in,
    output pixel_valid, pixel_data, pixel_index, frame_done,
    output pixel_count, frame_error, busy
  );

  modport master (
    output serial_in,
    input  pixel_valid, pixel_data, pixel_index, frame_done,
    input  pixel_count, frame_error, busy
  );
endinterface

// File: rtl/ws2811_stream_decoder.sv
// WS2811 one-wire receiver: times each high pulse to recover bits, packs 24-bit
// pixels MSB-first with their frame index, and reports the frame on the latch gap.
module ws2811_stream_decoder #(
  parameter int BIT_THRESH   = 30,
  parameter int MIN_HIGH     = 8,
  parameter int MAX_HIGH     = 60,
  parameter int RESET_CYCLES = 2500,
  parameter int MAX_LEDS     = 11
) (
  input  logic                   clock,
  input  logic                   reset,
  ws2811_stream_decoder_if.slave bus
);

  localparam logic [15:0] LP_BIT_THRESH = 16'(BIT_THRESH);
  localparam logic [15:0] LP_MIN_HIGH   = 16'(MIN_HIGH);
  localparam logic [15:0] LP_MAX_HIGH   = 16'(MAX_HIGH);
  localparam logic [15:0] LP_RESET      = 16'(RESET_CYCLES);
  localparam logic [7:0]  LP_MAX_LEDS   = 8'(MAX_LEDS);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_sync1, r_sync2, r_prev;
  logic        w_line, w_rise, w_fall;
  logic [15:0] r_hi_cnt, r_lo_cnt;
  logic [4:0]  r_bit_cnt;
  logic [7:0]  r_pix_cnt;
  logic [23:0] r_shift;
  logic [23:0] w_word;
  logic        w_start, w_stuck, w_bit_done, w_latch;
  logic        w_hi_clr, w_hi_inc, w_lo_clr, w_lo_inc;
  logic        r_pixel_valid, r_frame_done, r_frame_error, r_busy;
  logic [23:0] r_pixel_data;
  logic [7:0]  r_pixel_index, r_pixel_count;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_line = r_sync2;
  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;
  assign w_word = {r_shift[22:0], (r_hi_cnt > LP_BIT_THRESH)};

  // Two-flop synchronizer followed by the edge-detect history flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_SYNC;
    else        r_state <= w_state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_SYNC: w_state_nx = (!w_line && r_lo_cnt >= LP_RESET) ? ST_IDLE : ST_SYNC;
      ST_IDLE: w_state_nx = w_rise ? ST_HIGH : ST_IDLE;
      ST_HIGH: begin
        if (w_fall)                                w_state_nx = ST_LOW;
        else if (w_line && r_hi_cnt > LP_MAX_HIGH) w_state_nx = ST_SYNC;
        else                                       w_state_nx = ST_HIGH;
      end
      ST_LOW: begin
        if (w_rise)                    w_state_nx = ST_HIGH;
        else if (r_lo_cnt >= LP_RESET) w_state_nx = ST_IDLE;
        else                           w_state_nx = ST_LOW;
      end
      default: w_state_nx = ST_SYNC;
    endcase
  end

  // FSM output decode: per-state strobes steering the datapath.
  always_comb begin
    w_start    = 1'b0;
    w_stuck    = 1'b0;
    w_bit_done = 1'b0;
    w_latch    = 1'b0;
    w_hi_clr   = 1'b0;
    w_hi_inc   = 1'b0;
    w_lo_clr   = 1'b0;
    w_lo_inc   = 1'b0;
    case (r_state)
      ST_SYNC: begin
        w_lo_clr = w_line;
        w_lo_inc = ~w_line;
      end
      ST_IDLE: begin
        w_start  = w_rise;
        w_hi_clr = w_rise;
      end
      ST_HIGH: begin
        if (w_fall) begin
          w_bit_done = 1'b1;
          w_lo_clr   = 1'b1;
        end else if (w_line && r_hi_cnt > LP_MAX_HIGH) begin
          w_stuck  = 1'b1;
          w_lo_clr = 1'b1;
        end else begin
          w_hi_inc = 1'b1;
        end
      end
      ST_LOW: begin
        if (w_rise)                    w_hi_clr = 1'b1;
        else if (r_lo_cnt >= LP_RESET) w_latch  = 1'b1;
        else                           w_lo_inc = 1'b1;
      end
      default: w_lo_clr = 1'b1;
    endcase
  end

  // Counters, bit assembly and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hi_cnt      <= 16'd0;
      r_lo_cnt      <= 16'd0;
      r_bit_cnt     <= 5'd0;
      r_pix_cnt     <= 8'd0;
      r_shift       <= 24'd0;
      r_pixel_valid <= 1'b0;
      r_pixel_data  <= 24'd0;
      r_pixel_index <= 8'd0;
      r_frame_done  <= 1'b0;
      r_pixel_count <= 8'd0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      if (w_hi_clr)      r_hi_cnt <= 16'd0;
      else if (w_hi_inc) r_hi_cnt <= sat_inc(r_hi_cnt);
      if (w_lo_clr)      r_lo_cnt <= 16'd0;
      else if (w_lo_inc) r_lo_cnt <= sat_inc(r_lo_cnt);

      if (w_start) begin
        r_frame_error <= 1'b0;
        r_bit_cnt     <= 5'd0;
        r_pix_cnt     <= 8'd0;
        r_busy        <= 1'b1;
      end else if (w_stuck) begin
        r_frame_error <= 1'b1;
        r_busy        <= 1'b0;
      end else if (w_bit_done) begin
        r_shift <= w_word;
        // A glitch still contributes its (zero) bit so later pixels stay aligned.
        if (r_hi_cnt < LP_MIN_HIGH) r_frame_error <= 1'b1;
        if (r_bit_cnt == 5'd23) begin
          r_bit_cnt <= 5'd0;
          if (r_pix_cnt < LP_MAX_LEDS) begin
            r_pixel_valid <= 1'b1;
            r_pixel_data  <= w_word;
            r_pixel_index <= r_pix_cnt;
            r_pix_cnt     <= r_pix_cnt + 8'd1;
          end else begin
            r_frame_error <= 1'b1;
            r_pix_cnt     <= LP_MAX_LEDS;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end else if (w_latch) begin
        r_frame_done  <= 1'b1;
        r_pixel_count <= r_pix_cnt;
        r_busy        <= 1'b0;
        r_bit_cnt     <= 5'd0;
        if (r_bit_cnt != 5'd0) r_frame_error <= 1'b1;
      end
    end
  end

  assign bus.pixel_valid = r_pixel_valid;
  assign bus.pixel_data  = r_pixel_data;
  assign bus.pixel_index = r_pixel_index;
  assign bus.frame_done  = r_frame_done;
  assign bus.pixel_count = r_pixel_count;
  assign bus.frame_error = r_frame_error;
  assign bus.busy        = r_busy;

endmodule
